// File: rtl/seg_codes_pkg.sv
// Shared 7-segment display codes, source tags and scheduler state encoding.
// Codes 0-9 are the decimal digits; letters follow from 10; 30/31 are dash/blank.
package seg_codes_pkg;

  localparam logic [4:0] CODE_A     = 5'd10;
  localparam logic [4:0] CODE_C     = 5'd12;
  localparam logic [4:0] CODE_E     = 5'd14;
  localparam logic [4:0] CODE_H     = 5'd17;
  localparam logic [4:0] CODE_L     = 5'd21;
  localparam logic [4:0] CODE_O     = 5'd24;
  localparam logic [4:0] CODE_P     = 5'd25;
  localparam logic [4:0] CODE_DASH  = 5'd30;
  localparam logic [4:0] CODE_BLANK = 5'd31;

  localparam logic [1:0] SRC_BANNER = 2'b00;
  localparam logic [1:0] SRC_STATUS = 2'b01;
  localparam logic [1:0] SRC_NOTE   = 2'b10;

  typedef enum logic [1:0] {
    ST_BANNER = 2'd0,
    ST_STATUS = 2'd1,
    ST_NOTE   = 2'd2
  } disp_state_e;

  // p3 sits in the top bits so a packed cast matches the status_digits layout.
  typedef struct packed {
    logic [4:0] p3;
    logic [4:0] p2;
    logic [4:0] p1;
    logic [4:0] p0;
  } digits_t;

  function automatic logic [4:0] banner_code(input int unsigned i);
    logic [4:0] c;
    case (i)
      0:       c = CODE_H;
      1:       c = CODE_E;
      2:       c = CODE_L;
      3:       c = CODE_L;
      4:       c = CODE_O;
      default: c = CODE_BLANK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/seg_banner_rom.sv
// Idle banner content lookup: index in, display code out.
// Purely combinational; entries past the text are blank.
module seg_banner_rom
  import seg_codes_pkg::*;
#(
  parameter int BANNER_LEN = 8,
  localparam int IW = (BANNER_LEN > 1) ? $clog2(BANNER_LEN) : 1
) (
  input  logic [IW-1:0] idx,
  output logic [4:0]    code
);

  always_comb begin
    code = banner_code(32'(idx));
  end

endmodule

// File: rtl/seg_display_sched.sv
// Owns the four digit codes of the scanned display: live note > status page > scrolling banner.
// All outputs registered (one clk from input to p*/src); hold and scroll timing run on a 1 ms tick.
module seg_display_sched
  import seg_codes_pkg::*;
#(
  parameter int TICK_DIV   = 100000,
  parameter int HOLD_MS    = 500,
  parameter int SCROLL_MS  = 300,
  parameter int BANNER_LEN = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        note_valid,
  input  logic [4:0]  note_code,
  input  logic [4:0]  note_oct,
  input  logic        status_en,
  input  logic [19:0] status_digits,
  output logic [4:0]  p0,
  output logic [4:0]  p1,
  output logic [4:0]  p2,
  output logic [4:0]  p3,
  output logic [1:0]  src,
  output logic        tick_ms
);

  localparam int DW = (TICK_DIV > 1)   ? $clog2(TICK_DIV)    : 1;
  localparam int HW = (HOLD_MS > 0)    ? $clog2(HOLD_MS + 1) : 1;
  localparam int SW = (SCROLL_MS > 1)  ? $clog2(SCROLL_MS)   : 1;
  localparam int IW = (BANNER_LEN > 1) ? $clog2(BANNER_LEN)  : 1;

  localparam logic [DW-1:0] DIV_LAST    = DW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_INIT   = HW'(HOLD_MS);
  localparam logic [SW-1:0] SCROLL_LAST = SW'(SCROLL_MS - 1);
  localparam logic [IW-1:0] IDX_LAST    = IW'(BANNER_LEN - 1);

  logic [DW-1:0] div_q, div_d;
  logic          tick_q, tick_d;
  disp_state_e   state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [SW-1:0] scroll_q, scroll_d;
  logic [IW-1:0] idx_q, idx_d;
  digits_t       p_q, p_d;
  logic [1:0]    src_q, src_d;

  logic [IW-1:0] win_idx  [4];
  logic [4:0]    win_code [4];

  // Free-running ms divider; the strobe is high for the cycle after the wrap.
  always_comb begin
    tick_d = (div_q == DIV_LAST);
    div_d  = div_q + 1'b1;
    if (div_q == DIV_LAST) begin
      div_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (note_valid) begin
      state_d = ST_NOTE;
      hold_d  = HOLD_INIT;
    end else begin
      case (state_q)
        ST_NOTE: begin
          if (hold_q == '0) begin
            state_d = status_en ? ST_STATUS : ST_BANNER;
          end else if (tick_q) begin
            hold_d = hold_q - 1'b1;
          end
        end
        ST_STATUS: begin
          if (!status_en) begin
            state_d = ST_BANNER;
          end
        end
        ST_BANNER: begin
          if (status_en) begin
            state_d = ST_STATUS;
          end
        end
        default: state_d = ST_BANNER;
      endcase
    end
  end

  // Scroll position only survives while the banner stays up; any re-entry restarts at idx 0.
  always_comb begin
    scroll_d = '0;
    idx_d    = '0;
    if (state_q == ST_BANNER && state_d == ST_BANNER) begin
      scroll_d = scroll_q;
      idx_d    = idx_q;
      if (tick_q) begin
        if (scroll_q == SCROLL_LAST) begin
          scroll_d = '0;
          idx_d    = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
          scroll_d = scroll_q + 1'b1;
        end
      end
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_win
    logic [IW:0] sum;
    assign sum = {1'b0, idx_d} + (IW + 1)'(k);
    // idx < BANNER_LEN and k <= 3 <= BANNER_LEN-1, so one subtraction is a full modulo.
    assign win_idx[k] = (sum >= (IW + 1)'(BANNER_LEN)) ? IW'(sum - (IW + 1)'(BANNER_LEN))
                                                       : sum[IW-1:0];
    seg_banner_rom #(.BANNER_LEN(BANNER_LEN)) u_rom (
      .idx  (win_idx[k]),
      .code (win_code[k])
    );
  end

  always_comb begin
    p_d   = p_q;
    src_d = SRC_BANNER;
    case (state_d)
      ST_NOTE: begin
        src_d = SRC_NOTE;
        p_d.p2 = CODE_DASH;
        p_d.p3 = CODE_DASH;
        if (note_valid) begin
          p_d.p0 = note_code;
          p_d.p1 = note_oct;
        end
      end
      ST_STATUS: begin
        src_d = SRC_STATUS;
        p_d   = digits_t'(status_digits);
      end
      default: begin
        src_d  = SRC_BANNER;
        p_d.p0 = win_code[0];
        p_d.p1 = win_code[1];
        p_d.p2 = win_code[2];
        p_d.p3 = win_code[3];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      tick_q   <= 1'b0;
      state_q  <= ST_BANNER;
      hold_q   <= '0;
      scroll_q <= '0;
      idx_q    <= '0;
      p_q      <= {4{CODE_BLANK}};
      src_q    <= SRC_BANNER;
    end else begin
      div_q    <= div_d;
      tick_q   <= tick_d;
      state_q  <= state_d;
      hold_q   <= hold_d;
      scroll_q <= scroll_d;
      idx_q    <= idx_d;
      p_q      <= p_d;
      src_q    <= src_d;
    end
  end

  assign p0      = p_q.p0;
  assign p1      = p_q.p1;
  assign p2      = p_q.p2;
  assign p3      = p_q.p3;
  assign src     = src_q;
  assign tick_ms = tick_q;

endmodule

// File: tb/tb_seg_display_sched.sv
// Bench for seg_display_sched: directed scenarios with literal expectations plus
// randomized stimulus compared every cycle against a behavioural model.
module tb_seg_display_sched;

  localparam int T_DIV  = 4;
  localparam int HOLD   = 3;
  localparam int SCROLL = 2;
  localparam int BLEN   = 8;

  localparam int M_BANNER = 0;
  localparam int M_STATUS = 1;
  localparam int M_NOTE   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        note_valid = 1'b0;
  logic [4:0]  note_code = '0;
  logic [4:0]  note_oct = '0;
  logic        status_en = 1'b0;
  logic [19:0] status_digits = '0;
  logic [4:0]  p0, p1, p2, p3;
  logic [1:0]  src;
  logic        tick_ms;

  int checks = 0;
  int errors = 0;

  // H E L L O followed by blanks.
  int banner [BLEN] = '{17, 14, 21, 21, 24, 31, 31, 31};

  int m_mode, m_hold, m_scroll, m_idx, m_edges, m_code, m_oct;
  int exp_p [4];
  int exp_src, exp_tick;

  seg_display_sched #(
    .TICK_DIV   (T_DIV),
    .HOLD_MS    (HOLD),
    .SCROLL_MS  (SCROLL),
    .BANNER_LEN (BLEN)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .note_valid    (note_valid),
    .note_code     (note_code),
    .note_oct      (note_oct),
    .status_en     (status_en),
    .status_digits (status_digits),
    .p0            (p0),
    .p1            (p1),
    .p2            (p2),
    .p3            (p3),
    .src           (src),
    .tick_ms       (tick_ms)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_mode   = M_BANNER;
    m_hold   = 0;
    m_scroll = 0;
    m_idx    = 0;
    m_edges  = 0;
    m_code   = 31;
    m_oct    = 31;
    for (int k = 0; k < 4; k++) exp_p[k] = 31;
    exp_src  = 0;
    exp_tick = 0;
  endtask

  // One clock edge of the scheduler rules: priority note > status > banner,
  // a tick every T_DIV cycles counted from reset release.
  task automatic model_step();
    bit tick;
    int prev;
    tick = (m_edges > 0) && (m_edges % T_DIV == 0);
    prev = m_mode;
    if (note_valid) begin
      m_mode = M_NOTE;
      m_hold = HOLD;
      m_code = int'(note_code);
      m_oct  = int'(note_oct);
    end else if (m_mode == M_NOTE) begin
      if (m_hold == 0) m_mode = status_en ? M_STATUS : M_BANNER;
      else if (tick) m_hold--;
    end else if (m_mode == M_STATUS) begin
      if (!status_en) m_mode = M_BANNER;
    end else begin
      if (status_en) m_mode = M_STATUS;
      else if (tick) begin
        m_scroll++;
        if (m_scroll == SCROLL) begin
          m_scroll = 0;
          m_idx    = (m_idx + 1) % BLEN;
        end
      end
    end
    if (m_mode == M_BANNER && prev != M_BANNER) begin
      m_idx    = 0;
      m_scroll = 0;
    end
    m_edges++;
    exp_tick = (m_edges % T_DIV == 0) ? 1 : 0;
    case (m_mode)
      M_NOTE: begin
        exp_src  = 2;
        exp_p[0] = m_code;
        exp_p[1] = m_oct;
        exp_p[2] = 30;
        exp_p[3] = 30;
      end
      M_STATUS: begin
        exp_src = 1;
        for (int k = 0; k < 4; k++) exp_p[k] = (int'(status_digits) >> (5 * k)) & 31;
      end
      default: begin
        exp_src = 0;
        for (int k = 0; k < 4; k++) exp_p[k] = banner[(m_idx + k) % BLEN];
      end
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("p0", int'(p0), exp_p[0]);
      chk("p1", int'(p1), exp_p[1]);
      chk("p2", int'(p2), exp_p[2]);
      chk("p3", int'(p3), exp_p[3]);
      chk("src", int'(src), exp_src);
      chk("tick_ms", int'(tick_ms), exp_tick);
    end
  end

  initial begin
    int n;

    // Reset state and first banner window.
    repeat (3) @(negedge clk);
    chk("reset_p0", int'(p0), 31);
    chk("reset_src", int'(src), 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("boot_p0", int'(p0), 17);
    chk("boot_p1", int'(p1), 14);
    chk("boot_p2", int'(p2), 21);
    chk("boot_p3", int'(p3), 21);
    chk("boot_src", int'(src), 0);
    repeat (8) @(negedge clk);
    chk("scroll1_p0", int'(p0), 14);
    chk("scroll1_p3", int'(p3), 24);
    repeat (55) @(negedge clk);
    chk("idx7_p0", int'(p0), 31);
    chk("idx7_p1", int'(p1), 17);
    @(negedge clk);
    chk("wrap_p0", int'(p0), 17);
    chk("wrap_p3", int'(p3), 21);

    // Single-cycle note pulse, then hold of 3 ticks.
    #1 note_valid = 1'b1; note_code = 5'd5; note_oct = 5'd4;
    @(negedge clk);
    chk("note_p0", int'(p0), 5);
    chk("note_p1", int'(p1), 4);
    chk("note_p2", int'(p2), 30);
    chk("note_p3", int'(p3), 30);
    chk("note_src", int'(src), 2);
    #1 note_valid = 1'b0; note_code = 5'd9;
    n = 0;
    while (src != 2'b00 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("note_exit_cycles", n, 12);
    chk("note_exit_p0", int'(p0), 17);

    // Status page.
    #1 status_en = 1'b1; status_digits = {5'd4, 5'd3, 5'd2, 5'd1};
    @(negedge clk);
    chk("status_p0", int'(p0), 1);
    chk("status_p1", int'(p1), 2);
    chk("status_p2", int'(p2), 3);
    chk("status_p3", int'(p3), 4);
    chk("status_src", int'(src), 1);
    #1 status_en = 1'b0;
    @(negedge clk);
    chk("status_drop_src", int'(src), 0);
    chk("status_drop_p0", int'(p0), 17);

    // Note and status together; note wins, status resumes after hold.
    #1 status_en = 1'b1; note_valid = 1'b1; note_code = 5'd7; note_oct = 5'd3;
    @(negedge clk);
    chk("both_src", int'(src), 2);
    #1 note_valid = 1'b0;
    n = 0;
    while (src == 2'b10 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("both_timeout", (n < 40) ? 1 : 0, 1);
    chk("both_after_src", int'(src), 1);

    // Re-press after two ticks of hold reloads the hold.
    #1 note_valid = 1'b1;
    @(negedge clk);
    #1 note_valid = 1'b0;
    repeat (8) @(negedge clk);
    #1 note_valid = 1'b1;
    @(negedge clk);
    #1 note_valid = 1'b0;
    repeat (2 * T_DIV) @(negedge clk);
    chk("repress_held_src", int'(src), 2);
    n = 0;
    while (src == 2'b10 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("repress_timeout", (n < 40) ? 1 : 0, 1);

    // Asynchronous reset mid-hold.
    #1 note_valid = 1'b1;
    @(negedge clk);
    #1 note_valid = 1'b0; status_en = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_p0", int'(p0), 31);
    chk("arst_p2", int'(p2), 31);
    chk("arst_src", int'(src), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rerelease_p0", int'(p0), 17);
    chk("rerelease_src", int'(src), 0);

    // Randomized traffic, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      if ($urandom_range(15) == 0) note_valid = ~note_valid;
      if ($urandom_range(39) == 0) status_en = ~status_en;
      note_code     = 5'($urandom);
      note_oct      = 5'($urandom);
      status_digits = 20'($urandom);
      if ($urandom_range(599) == 0) begin
        rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
